alarm_trigger: RTL and testbench
================================

Name: alarm_trigger

Overview:
- Consumer side of the alarm-set register: reads the stored alarm time (SA_*, DONE_SET) and compares it against the running clock time.
- Rings on a match, handles STOP/SNOOZE buttons, and times out an unattended alarm.
- Returns a one-cycle DISABLE_TRIGGER pulse that clears the stored alarm, making it one-shot.
- Sits between the alarm-set register, the timekeeping core, and the buzzer/LED drivers.

Parameters:
- RING_TIMEOUT_S, 60, seconds of ringing before auto-disable.
- SNOOZE_S, 300, seconds of silence per snooze.
- MAX_SNOOZE, 3, maximum snoozes per alarm event (1..3).

Ports:
- CLK  in  1  system clock
- RESETN  in  1  asynchronous active-low reset
- SEC_TICK  in  1  one-CLK pulse per second, synchronous to CLK
- ALARM_EN  in  1  master alarm enable (level)
- DONE_SET  in  1  stored alarm valid
- SA_H10, SA_H1, SA_M10, SA_M1  in  4 each  stored alarm BCD digits; 4'hF = unset
- T_H10, T_H1, T_M10, T_M1, T_S10, T_S1  in  4 each  current time BCD
- STOP  in  1  stop button, asynchronous level, active-high
- SNOOZE  in  1  snooze button, asynchronous level, active-high
- ALARM_ON  out  1  high while RINGING
- BEEP  out  1  buzzer drive
- SNOOZE_ON  out  1  high while SNOOZE
- SNOOZE_CNT  out  2  snoozes used in the current event
- DISABLE_TRIGGER  out  1  one-CLK pulse that clears the stored alarm

Behaviour:
- Reset (RESETN=0, asynchronous): state IDLE; all outputs 0; all counters, synchronizers and match_q cleared.
- Button conditioning:
  - STOP and SNOOZE each pass through a 2-FF synchronizer plus a third FF for edge detection.
  - press = sync2 & ~sync3.
  - Effect is registered on the 3rd CLK rising edge after the first edge that samples the input high.
  - A held button produces exactly one press.
- valid = ALARM_EN & DONE_SET & no SA digit equal to 4'hF.
- match (combinational) = valid & SA_H10/H1/M10/M1 equal T_H10/H1/M10/M1 & T_S10==0 & T_S1==0.
- match_q is match registered every CLK. A trigger is match & ~match_q (rising edge only), so one matched second fires once.
- States:
  - IDLE: when valid, go to ARMED next edge.
  - ARMED:
    - valid=0 -> IDLE.
    - trigger -> RINGING; ring_cnt=0, beep_phase=1, SNOOZE_CNT=0.
  - RINGING:
    - ALARM_ON=1; BEEP = beep_phase; beep_phase toggles on each SEC_TICK.
    - ring_cnt increments on SEC_TICK.
    - STOP press -> DISABLE_TRIGGER pulse, then IDLE.
    - SNOOZE press with SNOOZE_CNT<MAX_SNOOZE -> SNOOZE; SNOOZE_CNT+1; snz_cnt=0.
    - SNOOZE press with SNOOZE_CNT==MAX_SNOOZE is ignored; ringing continues.
    - ring_cnt reaches RING_TIMEOUT_S-1 on a SEC_TICK -> DISABLE_TRIGGER pulse, then IDLE.
  - SNOOZE:
    - SNOOZE_ON=1; BEEP=0; snz_cnt increments on SEC_TICK.
    - snz_cnt reaches SNOOZE_S-1 on a SEC_TICK -> RINGING; ring_cnt=0, beep_phase=1; SNOOZE_CNT retained.
    - STOP press -> DISABLE_TRIGGER pulse, then IDLE.
    - SNOOZE press is ignored.
- Clearing the alarm:
  - DISABLE_TRIGGER is a registered output, high for exactly one CLK in the cycle the state becomes IDLE.
  - It is never asserted in any other case.
- Priorities:
  - STOP over SNOOZE press.
  - STOP over timeout or snooze expiry in the same cycle.
  - Timeout over SNOOZE press in the same cycle (alarm disabled).
- External loss of alarm:
  - DONE_SET=0 or ALARM_EN=0 while RINGING/SNOOZE -> IDLE next edge with no DISABLE_TRIGGER.
  - On that transition, ALARM_ON, BEEP and SNOOZE_ON drop in the same edge; SNOOZE_CNT clears on entry to IDLE.
- A trigger while in RINGING or SNOOZE has no effect.
- A SEC_TICK coinciding with a state transition is consumed by the destination state's counter reset; it does not count.
- Counter width: ceil(log2(max(RING_TIMEOUT_S, SNOOZE_S))) bits; no wrap is reachable.

Test Plan:
- Basic ring/stop: SA=07:30, DONE_SET=1, ALARM_EN=1; time steps 07:29:59 -> 07:30:00 -> ALARM_ON=1 one edge later, BEEP toggles per SEC_TICK; STOP held 5 cycles -> one DISABLE_TRIGGER pulse 3 edges after STOP, ALARM_ON=0, state IDLE.
- Snooze limit: RING_TIMEOUT_S=5, SNOOZE_S=3, MAX_SNOOZE=2.
  - Trigger, then SNOOZE -> SNOOZE_ON=1, SNOOZE_CNT=1.
  - After 3 ticks, ALARM_ON=1 again.
  - Second SNOOZE -> SNOOZE_CNT=2.
  - Third SNOOZE while ringing is ignored; after 5 ticks, DISABLE_TRIGGER pulses once.
- Sentinel/disable: SA_H10=4'hF with matching other digits -> no ring. ALARM_EN=0 at match time -> no ring, state IDLE.
- Simultaneous events: STOP and SNOOZE rise in the same cycle during RINGING -> DISABLE_TRIGGER=1, SNOOZE_CNT stays 0. Timeout tick and SNOOZE press in the same cycle -> disabled, no snooze.
- External cancel: DONE_SET drops during SNOOZE -> IDLE next edge, SNOOZE_ON=0, DISABLE_TRIGGER stays 0.
- Reset mid-operation: RESETN=0 during RINGING -> ALARM_ON, BEEP, SNOOZE_ON, SNOOZE_CNT and DISABLE_TRIGGER go 0 immediately without a clock. After release with the time still at HH:MM:00 matching, the rising-edge detector does not fire until the next match.

Source files
------------

// File: rtl/alarm_trigger.sv
// Alarm trigger: compares the stored alarm time against the running clock.
// It rings on a match, handles the stop and snooze buttons, and times out an unattended alarm.
// It pulses DISABLE_TRIGGER to clear the stored alarm so that each alarm fires only once.
module alarm_trigger #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       SEC_TICK,
    input  logic       ALARM_EN,
    input  logic       DONE_SET,
    input  logic [3:0] SA_H10,
    input  logic [3:0] SA_H1,
    input  logic [3:0] SA_M10,
    input  logic [3:0] SA_M1,
    input  logic [3:0] T_H10,
    input  logic [3:0] T_H1,
    input  logic [3:0] T_M10,
    input  logic [3:0] T_M1,
    input  logic [3:0] T_S10,
    input  logic [3:0] T_S1,
    input  logic       STOP,
    input  logic       SNOOZE,
    output logic       ALARM_ON,
    output logic       BEEP,
    output logic       SNOOZE_ON,
    output logic [1:0] SNOOZE_CNT,
    output logic       DISABLE_TRIGGER
);

    localparam int CNT_MAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_S - 1);
    localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_S - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       SNZ_LIMIT = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    state_t           state_r, state_nx_s;
    logic [2:0]       stop_sync_r, snz_sync_r;
    logic             match_q_r;
    logic [CNT_W-1:0] ring_cnt_r, ring_cnt_nx_s;
    logic [CNT_W-1:0] snz_cnt_r, snz_cnt_nx_s;
    logic             beep_r, beep_nx_s;
    logic [1:0]       snooze_cnt_r, snooze_cnt_nx_s;
    logic             disable_r, disable_nx_s;
    logic             alarm_on_r, snooze_on_r;
    logic             valid_s, match_s, trigger_s;
    logic             stop_press_s, snz_press_s, ring_done_s, snz_done_s;

    // An alarm is usable only when enabled, stored, and free of the 4'hF "unset" digit.
    assign valid_s = ALARM_EN & DONE_SET &
                     (SA_H10 != 4'hF) & (SA_H1 != 4'hF) & (SA_M10 != 4'hF) & (SA_M1 != 4'hF);
    assign match_s = valid_s & (SA_H10 == T_H10) & (SA_H1 == T_H1) &
                     (SA_M10 == T_M10) & (SA_M1 == T_M1) &
                     (T_S10 == 4'd0) & (T_S1 == 4'd0);
    // Only the first cycle of a matching second may fire.
    assign trigger_s    = match_s & ~match_q_r;
    assign stop_press_s = stop_sync_r[1] & ~stop_sync_r[2];
    assign snz_press_s  = snz_sync_r[1] & ~snz_sync_r[2];
    assign ring_done_s  = SEC_TICK & (ring_cnt_r == RING_LAST);
    assign snz_done_s   = SEC_TICK & (snz_cnt_r == SNZ_LAST);

    // Two-stage synchronizers for the buttons plus a third stage for rising-edge detection.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            stop_sync_r <= 3'b000;
            snz_sync_r  <= 3'b000;
            match_q_r   <= 1'b0;
        end else begin
            stop_sync_r <= {stop_sync_r[1:0], STOP};
            snz_sync_r  <= {snz_sync_r[1:0], SNOOZE};
            match_q_r   <= match_s;
        end
    end

    // Next-state logic. The priority order is: loss of alarm, then STOP, then timeout/expiry, then snooze.
    always_comb begin
        state_nx_s      = state_r;
        ring_cnt_nx_s   = ring_cnt_r;
        snz_cnt_nx_s    = snz_cnt_r;
        beep_nx_s       = beep_r;
        snooze_cnt_nx_s = snooze_cnt_r;
        disable_nx_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid_s) begin
                    state_nx_s = ST_ARMED;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!valid_s) begin
                    state_nx_s = ST_IDLE;
                end else if (trigger_s) begin
                    state_nx_s      = ST_RINGING;
                    ring_cnt_nx_s   = CNT_ZERO;
                    beep_nx_s       = 1'b1;
                    snooze_cnt_nx_s = 2'd0;
                end else begin
                    state_nx_s = ST_ARMED;
                end
            end
            ST_RINGING: begin
                if (!valid_s) begin
                    state_nx_s      = ST_IDLE;
                    beep_nx_s       = 1'b0;
                    snooze_cnt_nx_s = 2'd0;
                end else if (stop_press_s || ring_done_s) begin
                    state_nx_s      = ST_IDLE;
                    beep_nx_s       = 1'b0;
                    snooze_cnt_nx_s = 2'd0;
                    disable_nx_s    = 1'b1;
                end else if (snz_press_s && (snooze_cnt_r < SNZ_LIMIT)) begin
                    state_nx_s      = ST_SNOOZE;
                    beep_nx_s       = 1'b0;
                    snooze_cnt_nx_s = snooze_cnt_r + 2'd1;
                    snz_cnt_nx_s    = CNT_ZERO;
                end else if (SEC_TICK) begin
                    ring_cnt_nx_s = ring_cnt_r + CNT_ONE;
                    beep_nx_s     = ~beep_r;
                end else begin
                    state_nx_s = ST_RINGING;
                end
            end
            ST_SNOOZE: begin
                if (!valid_s) begin
                    state_nx_s      = ST_IDLE;
                    snooze_cnt_nx_s = 2'd0;
                end else if (stop_press_s) begin
                    state_nx_s      = ST_IDLE;
                    snooze_cnt_nx_s = 2'd0;
                    disable_nx_s    = 1'b1;
                end else if (snz_done_s) begin
                    state_nx_s    = ST_RINGING;
                    ring_cnt_nx_s = CNT_ZERO;
                    beep_nx_s     = 1'b1;
                end else if (SEC_TICK) begin
                    snz_cnt_nx_s = snz_cnt_r + CNT_ONE;
                end else begin
                    state_nx_s = ST_SNOOZE;
                end
            end
            default: begin
                state_nx_s      = ST_IDLE;
                beep_nx_s       = 1'b0;
                snooze_cnt_nx_s = 2'd0;
            end
        endcase
    end

    // State, counters and registered outputs; the outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r      <= ST_IDLE;
            ring_cnt_r   <= CNT_ZERO;
            snz_cnt_r    <= CNT_ZERO;
            beep_r       <= 1'b0;
            snooze_cnt_r <= 2'd0;
            disable_r    <= 1'b0;
            alarm_on_r   <= 1'b0;
            snooze_on_r  <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            ring_cnt_r   <= ring_cnt_nx_s;
            snz_cnt_r    <= snz_cnt_nx_s;
            beep_r       <= beep_nx_s;
            snooze_cnt_r <= snooze_cnt_nx_s;
            disable_r    <= disable_nx_s;
            alarm_on_r   <= (state_nx_s == ST_RINGING);
            snooze_on_r  <= (state_nx_s == ST_SNOOZE);
        end
    end

    assign ALARM_ON        = alarm_on_r;
    assign BEEP            = beep_r;
    assign SNOOZE_ON       = snooze_on_r;
    assign SNOOZE_CNT      = snooze_cnt_r;
    assign DISABLE_TRIGGER = disable_r;

endmodule

// File: tb/tb_alarm_trigger.sv
// Testbench for alarm_trigger. It drives scenario tasks with randomized timing and alarm times.
// It checks the outputs against fixed expectations and against a behavioural model based on seconds and modes.
module tb_alarm_trigger;

    localparam int RT = 5;
    localparam int SZ = 3;
    localparam int MX = 2;

    localparam int MODE_OFF   = 0;
    localparam int MODE_WAIT  = 1;
    localparam int MODE_RING  = 2;
    localparam int MODE_QUIET = 3;

    logic       CLK, RESETN, SEC_TICK, ALARM_EN, DONE_SET, STOP, SNOOZE;
    logic [3:0] SA_H10, SA_H1, SA_M10, SA_M1;
    logic [3:0] T_H10, T_H1, T_M10, T_M1, T_S10, T_S1;
    logic       ALARM_ON, BEEP, SNOOZE_ON, DISABLE_TRIGGER;
    logic [1:0] SNOOZE_CNT;

    int checks = 0;
    int failures = 0;

    int         m_mode, m_secs, m_snoozes;
    logic       m_disable, m_prev_match;
    logic [2:0] stop_hist, snz_hist;
    logic       mv, mmt, mtrig, mstop, msnz;
    logic [5:0] dut_o, mdl_o;

    alarm_trigger #(.RING_TIMEOUT_S(RT), .SNOOZE_S(SZ), .MAX_SNOOZE(MX)) dut (
        .CLK(CLK), .RESETN(RESETN), .SEC_TICK(SEC_TICK), .ALARM_EN(ALARM_EN), .DONE_SET(DONE_SET),
        .SA_H10(SA_H10), .SA_H1(SA_H1), .SA_M10(SA_M10), .SA_M1(SA_M1),
        .T_H10(T_H10), .T_H1(T_H1), .T_M10(T_M10), .T_M1(T_M1), .T_S10(T_S10), .T_S1(T_S1),
        .STOP(STOP), .SNOOZE(SNOOZE), .ALARM_ON(ALARM_ON), .BEEP(BEEP), .SNOOZE_ON(SNOOZE_ON),
        .SNOOZE_CNT(SNOOZE_CNT), .DISABLE_TRIGGER(DISABLE_TRIGGER)
    );

    // Free-running clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign dut_o = {ALARM_ON, BEEP, SNOOZE_ON, SNOOZE_CNT, DISABLE_TRIGGER};

    // Expected outputs. The beep is on during the even seconds of each ringing phase.
    always_comb begin
        mdl_o = {m_mode == MODE_RING, (m_mode == MODE_RING) && ((m_secs % 2) == 0),
                 m_mode == MODE_QUIET, 2'(m_snoozes), m_disable};
    end

    // Behavioural model. A button press takes effect two edges after its first sample.
    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_mode = MODE_OFF; m_secs = 0; m_snoozes = 0; m_disable = 1'b0;
            m_prev_match = 1'b0; stop_hist = 3'b000; snz_hist = 3'b000;
        end else begin
            mv = ALARM_EN && DONE_SET && SA_H10 != 4'hF && SA_H1 != 4'hF && SA_M10 != 4'hF && SA_M1 != 4'hF;
            mmt = mv && SA_H10 == T_H10 && SA_H1 == T_H1 && SA_M10 == T_M10 && SA_M1 == T_M1
                  && T_S10 == 4'd0 && T_S1 == 4'd0;
            mtrig = mmt && !m_prev_match;
            m_prev_match = mmt;
            mstop = stop_hist[1] && !stop_hist[2];
            msnz  = snz_hist[1] && !snz_hist[2];
            stop_hist = {stop_hist[1:0], STOP};
            snz_hist  = {snz_hist[1:0], SNOOZE};
            m_disable = 1'b0;
            case (m_mode)
                MODE_OFF:  if (mv) m_mode = MODE_WAIT;
                MODE_WAIT: begin
                    if (!mv) m_mode = MODE_OFF;
                    else if (mtrig) begin m_mode = MODE_RING; m_secs = 0; m_snoozes = 0; end
                end
                MODE_RING: begin
                    if (!mv) begin m_mode = MODE_OFF; m_snoozes = 0; end
                    else if (mstop || (SEC_TICK && m_secs + 1 == RT)) begin
                        m_mode = MODE_OFF; m_snoozes = 0; m_disable = 1'b1;
                    end else if (msnz && m_snoozes < MX) begin
                        m_mode = MODE_QUIET; m_snoozes++; m_secs = 0;
                    end else if (SEC_TICK) m_secs++;
                end
                default: begin
                    if (!mv) begin m_mode = MODE_OFF; m_snoozes = 0; end
                    else if (mstop) begin m_mode = MODE_OFF; m_snoozes = 0; m_disable = 1'b1; end
                    else if (SEC_TICK && m_secs + 1 == SZ) begin m_mode = MODE_RING; m_secs = 0; end
                    else if (SEC_TICK) m_secs++;
                end
            endcase
        end
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic tick();
        SEC_TICK = 1'b1;
        cyc();
        SEC_TICK = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    task automatic pick_alarm();
        SA_H10 = 4'($urandom_range(0, 1));
        SA_H1  = 4'($urandom_range(0, 9));
        SA_M10 = 4'($urandom_range(0, 5));
        SA_M1  = 4'($urandom_range(0, 9));
        T_H10 = SA_H10; T_H1 = SA_H1; T_M10 = SA_M10; T_M1 = SA_M1; T_S10 = 4'd0; T_S1 = 4'd7;
    endtask

    // Arms the alarm, then moves the time onto HH:MM:00 and off again; the alarm is ringing on return.
    task automatic trigger_alarm();
        DONE_SET = 1'b1; ALARM_EN = 1'b1; T_S1 = 4'd7;
        cyc(); cyc();
        T_S1 = 4'd0;
        cyc();
        T_S1 = 4'd1;
    endtask

    task automatic settle();
        STOP = 1'b0; SNOOZE = 1'b0; SEC_TICK = 1'b0; DONE_SET = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_reset();
        RESETN = 1'b1; SEC_TICK = 1'b0; ALARM_EN = 1'b0; DONE_SET = 1'b0; STOP = 1'b0; SNOOZE = 1'b0;
        SA_H10 = 4'hF; SA_H1 = 4'hF; SA_M10 = 4'hF; SA_M1 = 4'hF;
        T_H10 = 4'd0; T_H1 = 4'd0; T_M10 = 4'd0; T_M1 = 4'd0; T_S10 = 4'd0; T_S1 = 4'd0;
        #2 RESETN = 1'b0;
        #1;
        checks++;
        if (dut_o !== 6'b000000) begin failures++; $display("FAIL reset_outputs: got %b expected 000000", dut_o); end
        repeat (2) cyc();
        RESETN = 1'b1;
        cyc();
        checks++;
        if (dut_o !== mdl_o) begin failures++; $display("FAIL reset_model: got %b expected %b", dut_o, mdl_o); end
    endtask

    task automatic test_basic_ring();
        logic exp_beep;
        SA_H10 = 4'd0; SA_H1 = 4'd7; SA_M10 = 4'd3; SA_M1 = 4'd0;
        T_H10 = 4'd0; T_H1 = 4'd7; T_M10 = 4'd2; T_M1 = 4'd9; T_S10 = 4'd5; T_S1 = 4'd9;
        DONE_SET = 1'b1; ALARM_EN = 1'b1;
        cyc(); cyc();
        checks++;
        if (ALARM_ON !== 1'b0) begin failures++; $display("FAIL basic_pre_match: ALARM_ON=%b expected 0", ALARM_ON); end
        T_M10 = 4'd3; T_M1 = 4'd0; T_S10 = 4'd0; T_S1 = 4'd0;
        cyc();
        checks++;
        if (ALARM_ON !== 1'b1 || BEEP !== 1'b1) begin
            failures++; $display("FAIL basic_ring_on: ALARM_ON=%b BEEP=%b expected 1 1", ALARM_ON, BEEP);
        end
        T_S1 = 4'd1;
        exp_beep = 1'b1;
        for (int k = 0; k < 3; k++) begin
            gap();
            tick();
            exp_beep = ~exp_beep;
            checks++;
            if (BEEP !== exp_beep || ALARM_ON !== 1'b1) begin
                failures++; $display("FAIL basic_beep_toggle: BEEP=%b ALARM_ON=%b expected %b 1", BEEP, ALARM_ON, exp_beep);
            end
        end
        STOP = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            checks++;
            if (DISABLE_TRIGGER !== (i == 3) || ALARM_ON !== (i < 3)) begin
                failures++; $display("FAIL basic_stop cycle %0d: DISABLE=%b ALARM_ON=%b expected %b %b",
                                     i, DISABLE_TRIGGER, ALARM_ON, i == 3, i < 3);
            end
        end
        settle();
    endtask

    task automatic test_snooze_limit();
        pick_alarm();
        trigger_alarm();
        for (int round = 1; round <= 2; round++) begin
            SNOOZE = 1'b1;
            repeat (3) cyc();
            SNOOZE = 1'b0;
            checks++;
            if (SNOOZE_ON !== 1'b1 || ALARM_ON !== 1'b0 || BEEP !== 1'b0 || SNOOZE_CNT !== 2'(round)) begin
                failures++; $display("FAIL snooze_enter %0d: SNOOZE_ON=%b ALARM_ON=%b BEEP=%b CNT=%0d expected 1 0 0 %0d",
                                     round, SNOOZE_ON, ALARM_ON, BEEP, SNOOZE_CNT, round);
            end
            for (int k = 1; k <= SZ; k++) begin
                gap();
                tick();
                checks++;
                if (ALARM_ON !== (k == SZ) || SNOOZE_ON !== (k != SZ)) begin
                    failures++; $display("FAIL snooze_expire tick %0d: ALARM_ON=%b SNOOZE_ON=%b expected %b %b",
                                         k, ALARM_ON, SNOOZE_ON, k == SZ, k != SZ);
                end
            end
        end
        SNOOZE = 1'b1;
        repeat (4) cyc();
        SNOOZE = 1'b0;
        checks++;
        if (ALARM_ON !== 1'b1 || SNOOZE_ON !== 1'b0 || SNOOZE_CNT !== 2'd2) begin
            failures++; $display("FAIL snooze_limit_ignored: ALARM_ON=%b SNOOZE_ON=%b CNT=%0d expected 1 0 2",
                                 ALARM_ON, SNOOZE_ON, SNOOZE_CNT);
        end
        for (int k = 1; k <= RT; k++) begin
            gap();
            tick();
            checks++;
            if (DISABLE_TRIGGER !== (k == RT) || ALARM_ON !== (k != RT)) begin
                failures++; $display("FAIL ring_timeout tick %0d: DISABLE=%b ALARM_ON=%b expected %b %b",
                                     k, DISABLE_TRIGGER, ALARM_ON, k == RT, k != RT);
            end
        end
        cyc();
        checks++;
        if (DISABLE_TRIGGER !== 1'b0 || SNOOZE_CNT !== 2'd0) begin
            failures++; $display("FAIL timeout_pulse_width: DISABLE=%b CNT=%0d expected 0 0", DISABLE_TRIGGER, SNOOZE_CNT);
        end
        settle();
    endtask

    task automatic test_sentinel();
        pick_alarm();
        SA_H10 = 4'hF;
        DONE_SET = 1'b1; ALARM_EN = 1'b1;
        cyc(); cyc();
        T_S1 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (ALARM_ON !== 1'b0 || dut_o !== mdl_o) begin
                failures++; $display("FAIL sentinel_no_ring: got %b expected %b", dut_o, mdl_o);
            end
        end
        pick_alarm();
        ALARM_EN = 1'b0;
        cyc(); cyc();
        T_S1 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (ALARM_ON !== 1'b0) begin failures++; $display("FAIL disabled_no_ring: ALARM_ON=%b expected 0", ALARM_ON); end
        end
        ALARM_EN = 1'b1;
        repeat (3) cyc();
        checks++;
        if (ALARM_ON !== 1'b0) begin failures++; $display("FAIL enable_mid_match: ALARM_ON=%b expected 0", ALARM_ON); end
        T_S1 = 4'd1;
        cyc();
        T_S1 = 4'd0;
        cyc();
        checks++;
        if (ALARM_ON !== 1'b1) begin failures++; $display("FAIL next_match_rings: ALARM_ON=%b expected 1", ALARM_ON); end
        settle();
    endtask

    task automatic test_simultaneous();
        pick_alarm();
        trigger_alarm();
        STOP = 1'b1; SNOOZE = 1'b1;
        repeat (3) cyc();
        checks++;
        if (DISABLE_TRIGGER !== 1'b1 || SNOOZE_CNT !== 2'd0 || SNOOZE_ON !== 1'b0) begin
            failures++; $display("FAIL stop_over_snooze: DISABLE=%b CNT=%0d SNOOZE_ON=%b expected 1 0 0",
                                 DISABLE_TRIGGER, SNOOZE_CNT, SNOOZE_ON);
        end
        settle();
        pick_alarm();
        trigger_alarm();
        for (int k = 1; k < RT; k++) begin gap(); tick(); end
        SNOOZE = 1'b1;
        cyc(); cyc();
        tick();
        checks++;
        if (DISABLE_TRIGGER !== 1'b1 || SNOOZE_ON !== 1'b0 || SNOOZE_CNT !== 2'd0 || ALARM_ON !== 1'b0) begin
            failures++; $display("FAIL timeout_over_snooze: DISABLE=%b SNOOZE_ON=%b CNT=%0d ALARM_ON=%b expected 1 0 0 0",
                                 DISABLE_TRIGGER, SNOOZE_ON, SNOOZE_CNT, ALARM_ON);
        end
        settle();
    endtask

    task automatic test_external_cancel();
        pick_alarm();
        trigger_alarm();
        SNOOZE = 1'b1;
        repeat (3) cyc();
        SNOOZE = 1'b0;
        gap();
        checks++;
        if (SNOOZE_ON !== 1'b1) begin failures++; $display("FAIL cancel_setup: SNOOZE_ON=%b expected 1", SNOOZE_ON); end
        DONE_SET = 1'b0;
        cyc();
        checks++;
        if (dut_o !== 6'b000000) begin failures++; $display("FAIL external_cancel: got %b expected 000000", dut_o); end
        cyc();
        checks++;
        if (DISABLE_TRIGGER !== 1'b0) begin failures++; $display("FAIL cancel_no_disable: DISABLE=%b expected 0", DISABLE_TRIGGER); end
        settle();
    endtask

    task automatic test_reset_mid();
        pick_alarm();
        trigger_alarm();
        T_S1 = 4'd0;
        gap();
        tick();
        RESETN = 1'b0;
        #1;
        checks++;
        if (dut_o !== 6'b000000) begin failures++; $display("FAIL reset_mid_async: got %b expected 000000", dut_o); end
        repeat (2) cyc();
        RESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (ALARM_ON !== 1'b0 || dut_o !== mdl_o) begin
                failures++; $display("FAIL reset_no_refire: got %b expected %b", dut_o, mdl_o);
            end
        end
        T_S1 = 4'd1;
        cyc(); cyc();
        T_S1 = 4'd0;
        cyc();
        checks++;
        if (ALARM_ON !== 1'b1) begin failures++; $display("FAIL reset_next_match: ALARM_ON=%b expected 1", ALARM_ON); end
        settle();
    endtask

    task automatic test_random();
        pick_alarm();
        DONE_SET = 1'b1; ALARM_EN = 1'b1;
        for (int i = 0; i < 800; i++) begin
            SEC_TICK = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0) STOP = ~STOP;
            if ($urandom_range(0, 9) == 0) SNOOZE = ~SNOOZE;
            if ($urandom_range(0, 99) == 0) ALARM_EN = ~ALARM_EN;
            if (!DONE_SET && $urandom_range(0, 19) == 0) DONE_SET = 1'b1;
            if ($urandom_range(0, 3) == 0) T_S1 = 4'($urandom_range(0, 2));
            if ($urandom_range(0, 49) == 0) T_M1 = (T_M1 == SA_M1) ? 4'hA : SA_M1;
            if ($urandom_range(0, 149) == 0) SA_H1 = (SA_H1 == 4'hF) ? T_H1 : 4'hF;
            cyc();
            SEC_TICK = 1'b0;
            checks++;
            if (dut_o !== mdl_o) begin
                failures++; $display("FAIL random cycle %0d: got %b expected %b", i, dut_o, mdl_o);
            end
            if (m_disable) DONE_SET = 1'b0;
        end
        settle();
    endtask

    // Runs the test sequence and prints the summary line.
    initial begin
        test_reset();
        test_basic_ring();
        test_snooze_limit();
        test_sentinel();
        test_simultaneous();
        test_external_cancel();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
